// File: rtl/pd_inst_buf_pkg.sv
// Shared constants and types for the pre-decode instruction buffer slice.
// Opcode / REGIMM rt / SPECIAL funct encodings used by the branch classifier.
// Also carries the default width of the in-flight request counters.
package pd_inst_buf_pkg;

  localparam int OUTST_W_DEF = 2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] funct;
  } inst_fields_t;

  function automatic inst_fields_t split_inst(input logic [31:0] inst);
    return inst_fields_t'(inst);
  endfunction

endpackage

// File: rtl/pd_inst_buf_if.sv
// Bundle of pipeline-control, SRAM-return and PD-slot signals for pd_inst_buf.
// master drives the slot/control side and observes the slot result.
// slave is the buffer itself.
interface pd_inst_buf_if;

  logic        refresh;
  logic        stall;
  logic        req_fire;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        pd_empty;
  logic        pd_inst_req;
  logic        pd_addr_error;
  logic [31:0] pd_inst;
  logic        pd_inst_ok;
  logic        pd_wait;
  logic        pd_branch;

  modport master (
    output refresh, stall, req_fire, inst_data_ok, inst_rdata,
           pd_empty, pd_inst_req, pd_addr_error,
    input  pd_inst, pd_inst_ok, pd_wait, pd_branch
  );

  modport slave (
    input  refresh, stall, req_fire, inst_data_ok, inst_rdata,
           pd_empty, pd_inst_req, pd_addr_error,
    output pd_inst, pd_inst_ok, pd_wait, pd_branch
  );

endinterface

// File: rtl/pd_predecode.sv
// Combinational branch/jump classifier: inst -> is_branch.
// Zero latency; no state, no handshake.
// Shared with the decode stage so both agree on what counts as a branch.
module pd_predecode
  import pd_inst_buf_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_branch
);

  inst_fields_t f;
  logic         unused_fields;

  assign f             = split_inst(inst);
  assign unused_fields = ^{f.rs, f.rd, f.sa};

  // Match conditional branches, REGIMM branches, direct and register jumps.
  always_comb begin
    is_branch = 1'b0;
    case (f.op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: is_branch = 1'b1;
      OP_REGIMM:  is_branch = (f.rt == RT_BLTZ)   || (f.rt == RT_BGEZ) ||
                              (f.rt == RT_BLTZAL) || (f.rt == RT_BGEZAL);
      OP_SPECIAL: is_branch = (f.funct == FUNCT_JR) || (f.funct == FUNCT_JALR);
      default:    is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/pd_inst_buf.sv
// PD-slot instruction buffer: pairs SRAM returns with the slot, holds them under stall, drops stale returns after refresh.
// Latency: same cycle as inst_data_ok with PD_INST_BYPASS_EN defined, one cycle later otherwise.
// Backpressure: held word stays until stall falls; pd_wait asks the hazard unit to stall while data is missing.
module pd_inst_buf
  import pd_inst_buf_pkg::*;
#(
  parameter int OUTST_W = OUTST_W_DEF
)(
  input  logic         clk,
  input  logic         resetn,
  pd_inst_buf_if.slave bus
);

`ifdef PD_INST_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [OUTST_W-1:0] CNT_MAX  = '1;
  localparam logic [OUTST_W-1:0] CNT_ZERO = '0;
  localparam logic [OUTST_W-1:0] CNT_ONE  = OUTST_W'(1);

  logic [OUTST_W-1:0] outst_cnt, outst_nxt;
  logic [OUTST_W-1:0] disc_cnt, disc_nxt;
  logic               filled;
  logic [31:0]        buf_inst;

  logic               slot_idle;
  logic               discard;
  logic               accept;
  logic [31:0]        pd_inst;
  logic               pd_inst_ok;
  logic               pd_wait;
  logic               is_branch;

  // A slot with no fetch behind it (bubble, fault, no request) never waits for data.
  assign slot_idle = bus.pd_empty | bus.pd_addr_error | !bus.pd_inst_req;
  assign discard   = bus.inst_data_ok & (disc_cnt != CNT_ZERO);
  assign accept    = bus.inst_data_ok & (disc_cnt == CNT_ZERO) & bus.pd_inst_req &
                     !bus.pd_empty & !filled & !bus.refresh;

  // In-flight counter: saturate at both ends instead of wrapping.
  always_comb begin
    outst_nxt = outst_cnt;
    if (bus.req_fire && !bus.inst_data_ok) begin
      if (outst_cnt != CNT_MAX) outst_nxt = outst_cnt + CNT_ONE;
    end else if (!bus.inst_data_ok) begin
      outst_nxt = outst_cnt;
    end else if (!bus.req_fire) begin
      if (outst_cnt != CNT_ZERO) outst_nxt = outst_cnt - CNT_ONE;
    end
  end

  // Discard counter: refresh snapshots pre-flush requests not returning this cycle.
  always_comb begin
    disc_nxt = disc_cnt;
    if (bus.refresh) begin
      if (bus.inst_data_ok && (outst_cnt != CNT_ZERO)) disc_nxt = outst_cnt - CNT_ONE;
      else                                             disc_nxt = outst_cnt;
    end else if (discard) begin
      disc_nxt = disc_cnt - CNT_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outst_cnt <= CNT_ZERO;
      disc_cnt  <= CNT_ZERO;
    end else begin
      outst_cnt <= outst_nxt;
      disc_cnt  <= disc_nxt;
    end
  end

  // Holding register: without bypass every accepted word goes through the buffer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      filled   <= 1'b0;
      buf_inst <= 32'h0;
    end else begin
      if (accept) buf_inst <= bus.inst_rdata;
      if (bus.refresh)   filled <= 1'b0;
      else if (accept)   filled <= BYPASS ? bus.stall : 1'b1;
      else if (!bus.stall) filled <= 1'b0;
    end
  end

  // Slot result: idle slots show a nop, held data wins over the live SRAM word.
  always_comb begin
    pd_inst_ok = slot_idle | filled | (BYPASS & accept);
    pd_wait    = !pd_inst_ok & !bus.refresh;
    pd_inst    = 32'h0;
    if (slot_idle)   pd_inst = 32'h0;
    else if (filled) pd_inst = buf_inst;
    else if (BYPASS) pd_inst = bus.inst_rdata;
  end

  pd_predecode u_predecode (
    .inst      (pd_inst),
    .is_branch (is_branch)
  );

  assign bus.pd_inst    = pd_inst;
  assign bus.pd_inst_ok = pd_inst_ok;
  assign bus.pd_wait    = pd_wait;
  assign bus.pd_branch  = is_branch & pd_inst_ok;

  a_no_outst_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.req_fire && !bus.inst_data_ok && (outst_cnt == CNT_MAX)));

  a_no_outst_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.inst_data_ok && !bus.req_fire && (outst_cnt == CNT_ZERO)));

  a_no_data_while_filled: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.inst_data_ok && filled));

endmodule

// File: tb/tb_pd_inst_buf.sv
// Directed bench for pd_inst_buf with a scoreboard of expected slot words.
// Stimulus pushes expected {inst, branch} for every cycle the slot should present data.
// A negedge monitor pops and compares whenever the DUT presents an occupied, valid slot.
module tb_pd_inst_buf;

`ifdef PD_INST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic        br;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pd_inst_buf_if bus ();

  pd_inst_buf #(.OUTST_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic br);
    exp_t e;
    e.inst = d;
    e.br   = br;
    sb_q.push_back(e);
  endtask

  // Monitor: every presented occupied slot must match the next expected word.
  always @(negedge clk) begin
    if (resetn && bus.pd_inst_ok && bus.pd_inst_req && !bus.pd_empty && !bus.pd_addr_error) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_present: got pd_inst %h want no presented slot", bus.pd_inst);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_inst", bus.pd_inst, e.inst);
        chk("sb_branch", {31'b0, bus.pd_branch}, {31'b0, e.br});
        chk("sb_wait", {31'b0, bus.pd_wait}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slot();
    bus.pd_empty      = 1'b1;
    bus.pd_inst_req   = 1'b0;
    bus.pd_addr_error = 1'b0;
    bus.inst_data_ok  = 1'b0;
    bus.req_fire      = 1'b0;
    bus.refresh       = 1'b0;
    bus.stall         = 1'b0;
  endtask

  task automatic issue(input int n);
    repeat (n) begin
      idle_slot();
      bus.req_fire = 1'b1;
      step();
    end
    bus.req_fire = 1'b0;
  endtask

  task automatic wait_slot(input string name);
    idle_slot();
    bus.pd_empty    = 1'b0;
    bus.pd_inst_req = 1'b1;
    bus.stall       = 1'b1;
    @(negedge clk);
    chk({name, "_ok"}, {31'b0, bus.pd_inst_ok}, 32'h0);
    chk({name, "_wait"}, {31'b0, bus.pd_wait}, 32'h1);
    step();
  endtask

  task automatic stale(input logic [31:0] d, input string name);
    idle_slot();
    bus.pd_empty     = 1'b0;
    bus.pd_inst_req  = 1'b1;
    bus.stall        = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = d;
    @(negedge clk);
    chk({name, "_ok"}, {31'b0, bus.pd_inst_ok}, 32'h0);
    chk({name, "_wait"}, {31'b0, bus.pd_wait}, 32'h1);
    step();
    bus.inst_data_ok = 1'b0;
  endtask

  // Return d for the waiting slot; k = cycles the slot is held by stall.
  task automatic deliver(input logic [31:0] d, input logic br, input int k);
    int nh;
    idle_slot();
    bus.pd_empty     = 1'b0;
    bus.pd_inst_req  = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = d;
    bus.stall        = BYP ? (k > 0) : 1'b1;
    if (BYP) push_exp(d, br);
    @(negedge clk);
    chk("data_cycle_ok", {31'b0, bus.pd_inst_ok}, {31'b0, BYP});
    chk("data_cycle_wait", {31'b0, bus.pd_wait}, {31'b0, !BYP});
    step();
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'hDEADBEEF;
    nh = BYP ? k : k + 1;
    for (int i = 0; i < nh; i++) begin
      bus.stall = (i < nh - 1);
      push_exp(d, br);
      step();
    end
    wait_slot("after_leave");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_slot();
    bus.inst_rdata = 32'h0;
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_inst", bus.pd_inst, 32'h0);
    chk("rst_ok", {31'b0, bus.pd_inst_ok}, 32'h1);
    chk("rst_wait", {31'b0, bus.pd_wait}, 32'h0);
    chk("rst_branch", {31'b0, bus.pd_branch}, 32'h0);
    step();
    wait_slot("rst_not_filled");

    // Steady flow with a beq.
    issue(1);
    deliver(32'h10820003, 1'b1, 0);

    // Stall hold of a non-branch word.
    issue(1);
    deliver(32'h24020005, 1'b0, 3);

    // Refresh with two requests in flight, then a fresh jump.
    issue(2);
    idle_slot();
    bus.refresh = 1'b1;
    @(negedge clk);
    chk("refresh_wait", {31'b0, bus.pd_wait}, 32'h0);
    step();
    issue(1);
    stale(32'h10820003, "stale0");
    stale(32'h10820003, "stale1");
    deliver(32'h0800000A, 1'b1, 0);

    // Refresh, data return and new request in the same cycle.
    issue(2);
    idle_slot();
    bus.pd_empty     = 1'b0;
    bus.pd_inst_req  = 1'b1;
    bus.refresh      = 1'b1;
    bus.req_fire     = 1'b1;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h10820003;
    bus.stall        = 1'b1;
    @(negedge clk);
    chk("simul_ok", {31'b0, bus.pd_inst_ok}, 32'h0);
    chk("simul_wait", {31'b0, bus.pd_wait}, 32'h0);
    step();
    stale(32'h10820003, "simul_stale");
    deliver(32'h03E00008, 1'b1, 0);

    // Address error: nop presented, nothing to wait for.
    idle_slot();
    bus.pd_empty      = 1'b0;
    bus.pd_inst_req   = 1'b1;
    bus.pd_addr_error = 1'b1;
    bus.inst_rdata    = 32'h10820003;
    @(negedge clk);
    chk("aerr_inst", bus.pd_inst, 32'h0);
    chk("aerr_ok", {31'b0, bus.pd_inst_ok}, 32'h1);
    chk("aerr_wait", {31'b0, bus.pd_wait}, 32'h0);
    chk("aerr_branch", {31'b0, bus.pd_branch}, 32'h0);
    step();

    // Occupied slot without a request also shows a nop.
    idle_slot();
    bus.pd_empty   = 1'b0;
    bus.inst_rdata = 32'h0800000A;
    @(negedge clk);
    chk("noreq_inst", bus.pd_inst, 32'h0);
    chk("noreq_ok", {31'b0, bus.pd_inst_ok}, 32'h1);
    chk("noreq_branch", {31'b0, bus.pd_branch}, 32'h0);
    step();

    idle_slot();
    repeat (2) step();
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
